irq_vector_arbiter: RTL
=======================

Name: irq_vector_arbiter

Overview:
Downstream consumer of the wishbone-gen EIC interrupt outputs. Collects the wb_irq_o lines of up to G_NUM_SRC peripheral EICs and resynchronises them. Masks them, picks one by fixed priority, and presents a single CPU interrupt request with an encoded vector. Runs an ack / end-of-interrupt (EOI) handshake so each source is serviced exactly once per assertion.

Parameters:
G_NUM_SRC, 8, number of interrupt source lines (1..32)
G_VEC_W, 3, vector width; must satisfy 2**G_VEC_W >= G_NUM_SRC
G_SYNC, 1, 1 = two-flop synchroniser on each irq_src_i bit; 0 = inputs already in wb_clk_i domain

Ports:
wb_clk_i  in  1  system/Wishbone clock
rst_i  in  1  reset; asynchronous, active-high
irq_src_i  in  G_NUM_SRC  level interrupt requests (one EIC wb_irq_o per bit)
irq_mask_i  in  G_NUM_SRC  per-source enable; 1 = enabled; quasi-static
irq_o  out  1  interrupt request to CPU
irq_vec_o  out  G_VEC_W  index of the source being requested/serviced
irq_ack_i  in  1  single-cycle CPU acknowledge of irq_o
irq_eoi_i  in  1  single-cycle end-of-interrupt from CPU
in_service_o  out  1  high while a source is between ack and EOI
spurious_o  out  1  single-cycle pulse when a request is withdrawn before ack
spurious_cnt_o  out  16  count of spurious events

Behaviour:
- Reset (async assert, release synchronous to wb_clk_i):
  - irq_o=0, irq_vec_o=0, in_service_o=0, spurious_o=0, spurious_cnt_o=0.
  - Synchroniser flops = 0; FSM in IDLE.
- Qualification:
  - pend = sync(irq_src_i) & irq_mask_i.
  - Synchroniser adds 2 cycles when G_SYNC=1, 0 cycles when G_SYNC=0.
- Priority: lowest set index of pend wins (bit 0 highest priority).
- FSM states: IDLE, REQ, ACTIVE, HOLDOFF.
- IDLE:
  - If pend != 0: latch winning index into irq_vec_o, set irq_o=1, go to REQ.
  - Latency: irq_src_i rise to irq_o = 3 cycles (G_SYNC=1) or 1 cycle (G_SYNC=0).
- REQ:
  - irq_vec_o stays frozen even if a higher-priority source rises; no preemption.
  - irq_ack_i=1: next cycle irq_o=0, in_service_o=1, go to ACTIVE.
  - Latched source's pend bit falls (deassert or mask) and irq_ack_i=0:
    - next cycle irq_o=0, spurious_o pulses 1 cycle, spurious_cnt_o increments, go to IDLE.
    - spurious_cnt_o saturates at 0xFFFF.
  - Ack and withdrawal in the same cycle: ack wins, go to ACTIVE, no spurious.
  - irq_eoi_i in REQ is ignored.
- ACTIVE:
  - irq_o=0; irq_vec_o holds the serviced index.
  - irq_eoi_i=1: in_service_o=0, go to HOLDOFF.
  - irq_ack_i in ACTIVE is ignored.
- HOLDOFF:
  - One cycle, then go to IDLE.
  - Lets the EIC's wb_irq_o deassertion, after the CPU's ISR-clear write, propagate through the synchroniser before re-arbitration.
  - With G_SYNC=1 this state lasts 2 cycles, matching the synchroniser depth.
- irq_vec_o changes only on the IDLE→REQ transition.
- Mask changes:
  - Act only via pend.
  - Masking the latched source while ACTIVE does not abort service.
- Reset mid-operation: all state clears immediately; any outstanding ack/EOI is lost.
- At most one source is in service at a time; no nesting.

Test Plan:
1. G_SYNC=1, mask=0xFF, irq_src_i=0x04 → irq_o=1 three cycles later, irq_vec_o=2; pulse ack → irq_o=0, in_service_o=1; clear source, pulse EOI → in_service_o=0, irq_o stays 0.
2. irq_src_i=0x0A simultaneously → vec=1 first. After ack + EOI with bit 1 cleared → vec=3 requested after HOLDOFF.
3. During REQ with vec=5, raise bit 0 → vec stays 5 until EOI; then vec=0 is requested.
4. irq_src_i=0x10, drop it before ack → spurious_o one-cycle pulse, spurious_cnt_o=1, irq_o=0, FSM back to IDLE; ack in the same cycle as the drop → serviced, count unchanged.
5. mask=0xFE, irq_src_i=0x01 → irq_o never asserts; set mask bit 0 → irq_o=1 with vec=0 one cycle after pend rises.
6. Assert rst_i while ACTIVE → all outputs 0 immediately (async); after release with source still high → fresh request, vec correct.

Source files
------------

// File: rtl/irq_vector_arbiter.sv
// Fixed-priority interrupt arbiter in front of a single CPU irq line.
// Runs a request / ack / EOI handshake with spurious-withdrawal accounting.
module irq_vector_arbiter #(
    parameter int G_NUM_SRC = 8,
    parameter int G_VEC_W   = 3,
    parameter int G_SYNC    = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_i,
    input  logic [G_NUM_SRC-1:0] irq_src_i,
    input  logic [G_NUM_SRC-1:0] irq_mask_i,
    output logic                 irq_o,
    output logic [G_VEC_W-1:0]   irq_vec_o,
    input  logic                 irq_ack_i,
    input  logic                 irq_eoi_i,
    output logic                 in_service_o,
    output logic                 spurious_o,
    output logic [15:0]          spurious_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE,
        HOLDOFF
    } state_t;

    // HOLDOFF spans the synchroniser depth so a cleared source is seen low.
    localparam logic [1:0] HOLD_INIT = (G_SYNC != 0) ? 2'd1 : 2'd0;

    state_t               state_q, state_d;
    logic [G_VEC_W-1:0]   vec_q, vec_d;
    logic [1:0]           hold_q, hold_d;
    logic                 spur_q, spur_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [G_NUM_SRC-1:0] src_s;
    logic [G_NUM_SRC-1:0] pend;
    logic [G_VEC_W-1:0]   win;

    generate
        if (G_SYNC != 0) begin : g_sync
            logic [G_NUM_SRC-1:0] s1_q, s2_q;
            always_ff @(posedge wb_clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= irq_src_i;
                    s2_q <= s1_q;
                end
            end
            assign src_s = s2_q;
        end else begin : g_nosync
            assign src_s = irq_src_i;
        end
    endgenerate

    assign pend = src_s & irq_mask_i;

    always_comb begin
        win = '0;
        for (int i = G_NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) win = G_VEC_W'(i);
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            spur_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            spur_q  <= spur_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        spur_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    state_d = REQ;
                    vec_d   = win;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = ACTIVE;
                end else if (!pend[vec_q]) begin
                    state_d = IDLE;
                    spur_d  = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end
            ACTIVE: begin
                if (irq_eoi_i) begin
                    state_d = HOLDOFF;
                    hold_d  = HOLD_INIT;
                end
            end
            HOLDOFF: begin
                if (hold_q == 2'd0) state_d = IDLE;
                else hold_d = hold_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_o          = (state_q == REQ);
    assign in_service_o   = (state_q == ACTIVE);
    assign irq_vec_o      = vec_q;
    assign spurious_o     = spur_q;
    assign spurious_cnt_o = cnt_q;

endmodule
